// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN,
        FAULT
    } seq_state_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and reset-domain-side signals of the sequencer.
interface pll_reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              pll_locked;
    logic              pll_resetb;
    logic [STAGES-1:0] rst_n_out;
    logic              ready;
    logic              fault;
    logic [7:0]        lock_loss_count;

    modport master (
        input  pll_locked,
        output pll_resetb,
        output rst_n_out,
        output ready,
        output fault,
        output lock_loss_count
    );

    modport slave (
        output pll_locked,
        input  pll_resetb,
        input  rst_n_out,
        input  ready,
        input  fault,
        input  lock_loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-stage synchronizer with synchronous active-low reset to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset supervisor: pulses RESETB, qualifies lock with timeout/retries,
// releases staged downstream resets, and restarts on lock loss.
//
// state     | meaning
// PLL_RESET | pll_resetb held low for RESET_CYCLES
// WAIT_LOCK | pll_resetb high, waiting for synced lock, timeout running
// STABILIZE | counting consecutive lock-high cycles, timeout running
// RELEASE   | releasing rst_n_out bits one STAGE_GAP apart
// RUN       | all stages released, ready high
// FAULT     | retries exhausted, everything held in reset until reset_n
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 12000,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGES        = 3,
    parameter int STAGE_GAP     = 16,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    pll_reset_sequencer_if.master seq_if
);
    localparam int STAGE_SPAN = STAGES * STAGE_GAP;
    localparam int CNT_MAX_A  = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_A > STAGE_SPAN) ? CNT_MAX_A : STAGE_SPAN;
    localparam int CNT_W      = cnt_width(CNT_MAX);
    localparam int TMO_W      = cnt_width(LOCK_TIMEOUT);
    localparam int RTY_W      = cnt_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPAN_LAST   = CNT_W'(STAGE_SPAN - 1);
    localparam logic [TMO_W-1:0] TMO_ONE     = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_ONE     = RTY_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);

    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo;
    logic [RTY_W-1:0]  retries;
    logic [7:0]        loss_cnt;
    logic              lock_sync;
    logic              pll_resetb_q;
    logic [STAGES-1:0] rst_q;
    logic              ready_q;
    logic              fault_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (seq_if.pll_locked),
        .q     (lock_sync)
    );

    // Stage k is released once elapsed RELEASE time reaches k*STAGE_GAP.
    function automatic logic [STAGES-1:0] stage_mask(input logic [CNT_W-1:0] elapsed);
        logic [STAGES-1:0] m;
        m = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (int'(elapsed) >= k * STAGE_GAP) m[k] = 1'b1;
        end
        return m;
    endfunction

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            tmo          <= '0;
            retries      <= '0;
            loss_cnt     <= '0;
            pll_resetb_q <= 1'b0;
            rst_q        <= '0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (cnt == RESET_LAST) begin
                        state        <= WAIT_LOCK;
                        cnt          <= '0;
                        tmo          <= '0;
                        pll_resetb_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_LOCK, STABILIZE: begin
                    tmo <= tmo + TMO_ONE;
                    // Timeout is checked first so it wins over a same-cycle lock drop.
                    if (tmo == TMO_LAST) begin
                        cnt          <= '0;
                        pll_resetb_q <= 1'b0;
                        if (retries == RTY_MAX) begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state   <= PLL_RESET;
                            retries <= retries + RTY_ONE;
                        end
                    end else if (state == WAIT_LOCK) begin
                        if (lock_sync) begin
                            state <= STABILIZE;
                            cnt   <= '0;
                        end
                    end else if (!lock_sync) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        rst_q <= stage_mask('0);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_sync) begin
                        state        <= PLL_RESET;
                        cnt          <= '0;
                        tmo          <= '0;
                        retries      <= '0;
                        pll_resetb_q <= 1'b0;
                        rst_q        <= '0;
                        ready_q      <= 1'b0;
                        if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
                    end else if (state == RELEASE) begin
                        if (cnt == SPAN_LAST) begin
                            state   <= RUN;
                            retries <= '0;
                            rst_q   <= '1;
                            ready_q <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                            rst_q <= stage_mask(cnt + CNT_ONE);
                        end
                    end
                end
                FAULT: begin
                    pll_resetb_q <= 1'b0;
                    rst_q        <= '0;
                    ready_q      <= 1'b0;
                    fault_q      <= 1'b1;
                end
                default: begin
                    state        <= PLL_RESET;
                    cnt          <= '0;
                    pll_resetb_q <= 1'b0;
                    rst_q        <= '0;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.pll_resetb      = pll_resetb_q;
    assign seq_if.rst_n_out       = rst_q;
    assign seq_if.ready           = ready_q;
    assign seq_if.fault           = fault_q;
    assign seq_if.lock_loss_count = loss_cnt;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock activity,
// checked every cycle against a timeline-level model of the sequencer.
module tb_pll_reset_sequencer;
    localparam int RC   = 4;
    localparam int TO   = 50;
    localparam int SC   = 8;
    localparam int NST  = 3;
    localparam int GAP  = 5;
    localparam int MR   = 2;
    localparam int SPAN = NST * GAP;

    logic clk;
    logic reset_n;
    pll_reset_sequencer_if #(.STAGES(NST)) bus ();

    pll_reset_sequencer #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .STAGES        (NST),
        .STAGE_GAP     (GAP),
        .MAX_RETRIES   (MR)
    ) dut (
        .clock_in (clk),
        .reset_n  (reset_n),
        .seq_if   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    int nprint = 0;
    int cyc = 0;

    // Model: the PLL is either being pulsed, being searched for lock (needs SC+1
    // consecutive synced highs inside a TO-cycle window), live (stage k on once
    // live time >= k*GAP), or dead.
    typedef enum int {M_PULSE, M_SEEK, M_LIVE, M_DEAD} mphase_e;
    mphase_e mph = M_PULSE;
    int  mt = 0, mwin = 0, mrun = 0, mtries = 0, mloss = 0;
    bit  mh1 = 0, mh2 = 0, mvalid = 0;

    always @(posedge clk) begin
        bit lk;
        cyc++;
        if (!reset_n) begin
            mph = M_PULSE; mt = 0; mwin = 0; mrun = 0; mtries = 0; mloss = 0;
            mh1 = 0; mh2 = 0; mvalid = 1;
        end else begin
            lk  = mh2;
            mh2 = mh1;
            mh1 = (bus.pll_locked === 1'b1);
            case (mph)
                M_PULSE: begin
                    mt++;
                    if (mt == RC) begin mph = M_SEEK; mwin = 0; mrun = 0; end
                end
                M_SEEK: begin
                    mwin++;
                    if (mwin == TO) begin
                        if (mtries == MR) mph = M_DEAD;
                        else begin mtries++; mph = M_PULSE; mt = 0; end
                    end else begin
                        mrun = lk ? mrun + 1 : 0;
                        if (mrun == SC + 1) begin mph = M_LIVE; mt = 0; end
                    end
                end
                M_LIVE: begin
                    if (!lk) begin
                        mloss = (mloss < 255) ? mloss + 1 : 255;
                        mph = M_PULSE; mt = 0; mtries = 0;
                    end else begin
                        mt++;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        bit         e_rb, e_rdy, e_flt;
        logic [2:0] e_rst;
        if (mvalid) begin
            e_rb  = (mph == M_SEEK) || (mph == M_LIVE);
            e_flt = (mph == M_DEAD);
            e_rdy = (mph == M_LIVE) && (mt >= SPAN);
            for (int k = 0; k < NST; k++) e_rst[k] = (mph == M_LIVE) && (mt >= k * GAP);
            vectors++;
            if (bus.pll_resetb !== e_rb || bus.rst_n_out !== e_rst || bus.ready !== e_rdy ||
                bus.fault !== e_flt || bus.lock_loss_count !== 8'(mloss)) begin
                miscompares++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL cycle_check @%0d: got resetb=%b rst=%b ready=%b fault=%b loss=%0d, want resetb=%b rst=%b ready=%b fault=%b loss=%0d",
                             cyc, bus.pll_resetb, bus.rst_n_out, bus.ready, bus.fault, bus.lock_loss_count,
                             e_rb, e_rst, e_rdy, e_flt, mloss);
                end
            end
        end
    end

    // Event log of output edges, stamped with the clock edge that produced them.
    int rise_q[$];
    int fall_q[$];
    int rst_rise[NST];
    int rdy_rise = -1, rdy_fall = -1, flt_rise = -1;
    bit any_rst = 0;
    bit p_rb = 0, p_rdy = 0, p_flt = 0;
    logic [2:0] p_rst = '0;

    always @(negedge clk) begin
        if (bus.pll_resetb === 1'b1 && !p_rb) rise_q.push_back(cyc);
        if (bus.pll_resetb === 1'b0 && p_rb)  fall_q.push_back(cyc);
        for (int k = 0; k < NST; k++)
            if (bus.rst_n_out[k] === 1'b1 && !p_rst[k]) rst_rise[k] = cyc;
        if (bus.ready === 1'b1 && !p_rdy) rdy_rise = cyc;
        if (bus.ready === 1'b0 && p_rdy)  rdy_fall = cyc;
        if (bus.fault === 1'b1 && !p_flt) flt_rise = cyc;
        if (bus.rst_n_out !== 3'b000) any_rst = 1;
        p_rb  = (bus.pll_resetb === 1'b1);
        p_rdy = (bus.ready === 1'b1);
        p_flt = (bus.fault === 1'b1);
        for (int k = 0; k < NST; k++) p_rst[k] = (bus.rst_n_out[k] === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic bit probe(input int which);
        case (which)
            0:       return bus.pll_resetb === 1'b1;
            1:       return bus.rst_n_out[0] === 1'b1;
            2:       return bus.ready === 1'b1;
            3:       return bus.fault === 1'b1;
            4:       return bus.ready === 1'b0;
            default: return bus.pll_resetb === 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string name);
        int n;
        n = 0;
        while (!probe(which) && n < limit) begin
            tick();
            n++;
        end
        if (!probe(which)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: condition not reached within %0d cycles", name, limit);
        end
    endtask

    task automatic do_reset(output int rel);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rel = cyc;
        rise_q.delete();
        fall_q.delete();
        any_rst = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_resetb"}, int'(bus.pll_resetb), 0);
        chk({tag, "_rst"},    int'(bus.rst_n_out), 0);
        chk({tag, "_ready"},  int'(bus.ready), 0);
        chk({tag, "_fault"},  int'(bus.fault), 0);
        chk({tag, "_loss"},   int'(bus.lock_loss_count), 0);
    endtask

    initial begin
        int rel, p, x, len;
        bit lv;
        reset_n = 1'b0;
        bus.pll_locked = 1'b0;
        tick();
        tick();

        // Nominal bring-up
        do_reset(rel);
        check_reset_values("reset");
        wait_for(0, 20, "nominal_resetb_rise");
        p = cyc;
        chk("nominal_resetb_low", p - rel, RC);
        while (cyc < p + 10) tick();
        x = cyc;
        bus.pll_locked = 1'b1;
        wait_for(2, 100, "nominal_ready");
        chk("nominal_rst0_delay", rst_rise[0] - x, 2 + SC + 1);
        chk("nominal_rst1_gap",   rst_rise[1] - rst_rise[0], GAP);
        chk("nominal_rst2_gap",   rst_rise[2] - rst_rise[0], 2 * GAP);
        chk("nominal_ready_gap",  rdy_rise - rst_rise[0], 3 * GAP);
        chk("nominal_fault",      int'(bus.fault), 0);

        // One-cycle lock drop in RUN
        repeat (5) tick();
        rise_q.delete();
        x = cyc;
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        wait_for(4, 10, "drop_ready_fall");
        chk("drop_latency", rdy_fall - x, 3);
        chk("drop_rst",     int'(bus.rst_n_out), 0);
        chk("drop_count",   int'(bus.lock_loss_count), 1);
        wait_for(2, 200, "drop_resequence");
        chk("drop_repulse", rise_q.size(), 1);

        // Saturation of the loss counter
        for (int i = 0; i < 300; i++) begin
            wait_for(1, 80, "sat_release");
            bus.pll_locked = 1'b0;
            tick();
            bus.pll_locked = 1'b1;
            wait_for(5, 10, "sat_loss");
        end
        chk("sat_count", int'(bus.lock_loss_count), 255);

        // Reset pulse in the middle of RELEASE
        wait_for(1, 80, "rr_release");
        tick();
        tick();
        do_reset(rel);
        check_reset_values("rr");
        wait_for(0, 20, "rr_resetb_rise");
        chk("rr_resetb_low", rise_q.size() > 0 ? rise_q[0] - rel : -1, RC);

        // Never locks: three pulses then sticky fault
        bus.pll_locked = 1'b0;
        do_reset(rel);
        wait_for(3, 400, "never_fault");
        chk("never_pulses", rise_q.size(), 3);
        chk("never_timeouts", fall_q.size(), 3);
        if (rise_q.size() == 3 && fall_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("never_high_len", fall_q[i] - rise_q[i], TO);
            for (int i = 0; i < 2; i++) chk("never_pulse_len", rise_q[i+1] - fall_q[i], RC);
            chk("never_fault_time", flt_rise, fall_q[2]);
        end
        for (int i = 0; i < 60; i++) begin
            bus.pll_locked = 1'($urandom_range(0, 1));
            tick();
        end
        chk("never_fault_held",  int'(bus.fault), 1);
        chk("never_resetb_held", int'(bus.pll_resetb), 0);

        // Glitchy lock: 5 high / 1 low never qualifies
        do_reset(rel);
        for (int i = 0; i < 130; i++) begin
            bus.pll_locked = ((i % 6) < 5);
            tick();
        end
        chk("glitch_no_release", int'(any_rst), 0);
        chk("glitch_pulses", rise_q.size(), 3);

        // Timeout coincides with a lock drop in STABILIZE
        bus.pll_locked = 1'b0;
        do_reset(rel);
        wait_for(0, 20, "coin_resetb_rise");
        p = cyc;
        while (cyc < p + 42) tick();
        bus.pll_locked = 1'b1;
        while (cyc < p + 47) tick();
        bus.pll_locked = 1'b0;
        wait_for(5, 20, "coin_resetb_fall");
        chk("coin_fall_time", fall_q.size() > 0 ? fall_q[0] - p : -1, TO);
        chk("coin_fault", int'(bus.fault), 0);
        wait_for(0, 20, "coin_resetb_rise2");
        chk("coin_pulse_len", (rise_q.size() > 1 && fall_q.size() > 0) ? rise_q[1] - fall_q[0] : -1, RC);

        // Random lock activity with occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            len = $urandom_range(1, 40);
            lv  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) do_reset(rel);
            for (int j = 0; j < len; j++) begin
                bus.pll_locked = lv;
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
